rvb_pcpi_host: RTL

//  PCPI initiator: takes one instruction plus operands on a valid/ready stream and issues it on PCPI.

---
 rtl/rvb_pcpi_pkg.sv | 18 +
 rtl/rvb_pcpi_host_timer.sv | 39 +++
 rtl/rvb_pcpi_host.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rvb_pcpi_pkg.sv
// Shared definitions for the PCPI host and bench-side responder models.
package rvb_pcpi_pkg;

   localparam int unsigned PCPI_TIMEOUT_DEFAULT  = 16;
   localparam int unsigned PCPI_WATCHDOG_DEFAULT = 1024;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } pcpi_host_state_e;

   // Bits needed to count from 0 up to and including limit.
   function automatic int unsigned host_cnt_width(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/rvb_pcpi_host_timer.sv
// Clear/enable saturating cycle counter with hit flags at TimeoutVal-1 and WatchdogVal-1.
module rvb_pcpi_host_timer #(
   parameter int unsigned CntW        = 5,
   parameter int unsigned TimeoutVal  = 16,
   parameter int unsigned WatchdogVal = 1024
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_hit_o,
   output logic watchdog_hit_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_hit_o  = (cnt_q == CntW'(TimeoutVal - 1));
   assign watchdog_hit_o = (cnt_q == CntW'(WatchdogVal - 1));

endmodule

// File: rtl/rvb_pcpi_host.sv
// PCPI initiator: accepts one instruction on din, issues it on PCPI, returns rd on dout.
// Unclaimed instructions are reported illegal after TIMEOUT cycles.
// Optional hard abort after WATCHDOG cycles when RVB_PCPI_HOST_WATCHDOG_EN is defined.
module rvb_pcpi_host
   import rvb_pcpi_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned TIMEOUT  = PCPI_TIMEOUT_DEFAULT,
   parameter int unsigned WATCHDOG = PCPI_WATCHDOG_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            din_valid,
   output logic            din_ready,
   input  logic [31:0]     din_insn,
   input  logic [XLEN-1:0] din_rs1,
   input  logic [XLEN-1:0] din_rs2,
   input  logic [XLEN-1:0] din_rs3,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic [XLEN-1:0] dout_rd,
   output logic            dout_wr,
   output logic            dout_illegal,
   output logic            dout_timeout,
   output logic            pcpi_valid,
   output logic [31:0]     pcpi_insn,
   output logic [XLEN-1:0] pcpi_rs1,
   output logic [XLEN-1:0] pcpi_rs2,
   output logic [XLEN-1:0] pcpi_rs3,
   input  logic            pcpi_wr,
   input  logic [XLEN-1:0] pcpi_rd,
   input  logic            pcpi_wait,
   input  logic            pcpi_ready
);

`ifdef RVB_PCPI_HOST_WATCHDOG_EN
   localparam int unsigned CntW = host_cnt_width(WATCHDOG);
`else
   localparam int unsigned CntW = host_cnt_width(TIMEOUT);
`endif

   pcpi_host_state_e state_q, state_d;

   logic [31:0]     insn_q;
   logic [XLEN-1:0] rs1_q, rs2_q, rs3_q;
   logic [XLEN-1:0] rd_q, rd_d;
   logic            wr_q, wr_d;
   logic            illegal_q, illegal_d;
   logic            timeout_q, timeout_d;
   logic            seen_wait_q, seen_wait_d;

   logic din_hs;
   logic timeout_hit;
   logic watchdog_hit;

   assign din_ready  = (state_q == StIdle);
   assign din_hs     = din_valid && din_ready;
   assign pcpi_valid = (state_q == StIssue);
   assign dout_valid = (state_q == StResp);

   assign pcpi_insn    = insn_q;
   assign pcpi_rs1     = rs1_q;
   assign pcpi_rs2     = rs2_q;
   assign pcpi_rs3     = rs3_q;
   assign dout_rd      = rd_q;
   assign dout_wr      = wr_q;
   assign dout_illegal = illegal_q;
   assign dout_timeout = timeout_q;

   rvb_pcpi_host_timer #(
      .CntW        (CntW),
      .TimeoutVal  (TIMEOUT),
      .WatchdogVal (WATCHDOG)
   ) u_timer (
      .clock_i        (clock),
      .reset_i        (reset),
      .clr_i          (din_hs),
      .en_i           (pcpi_valid),
      .timeout_hit_o  (timeout_hit),
      .watchdog_hit_o (watchdog_hit)
   );

`ifndef RVB_PCPI_HOST_WATCHDOG_EN
   logic unused_watchdog;
   assign unused_watchdog = watchdog_hit;
`endif

   // Next-state and response capture.
   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      illegal_d   = illegal_q;
      timeout_d   = timeout_q;
      seen_wait_d = seen_wait_q;
      unique case (state_q)
         StIdle: begin
            if (din_valid) begin
               seen_wait_d = 1'b0;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (pcpi_wait) begin
               seen_wait_d = 1'b1;
            end
            // A result always beats an expiring timeout in the same cycle.
            if (pcpi_ready) begin
               rd_d      = pcpi_wr ? pcpi_rd : '0;
               wr_d      = pcpi_wr;
               illegal_d = 1'b0;
               timeout_d = 1'b0;
               state_d   = StResp;
            end else if (!seen_wait_q && !pcpi_wait && timeout_hit) begin
               rd_d      = '0;
               wr_d      = 1'b0;
               illegal_d = 1'b1;
               timeout_d = 1'b0;
               state_d   = StResp;
`ifdef RVB_PCPI_HOST_WATCHDOG_EN
            end else if (watchdog_hit) begin
               // Abort even a claimed instruction; the responder needs a reset afterwards.
               rd_d      = '0;
               wr_d      = 1'b0;
               illegal_d = 1'b0;
               timeout_d = 1'b1;
               state_d   = StResp;
`endif
            end
         end
         StResp: begin
            if (dout_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         rd_q        <= '0;
         wr_q        <= 1'b0;
         illegal_q   <= 1'b0;
         timeout_q   <= 1'b0;
         seen_wait_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         illegal_q   <= illegal_d;
         timeout_q   <= timeout_d;
         seen_wait_q <= seen_wait_d;
      end
   end

   // Instruction and operand capture on the din handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         insn_q <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rs3_q  <= '0;
      end else if (din_hs) begin
         insn_q <= din_insn;
         rs1_q  <= din_rs1;
         rs2_q  <= din_rs2;
         rs3_q  <= din_rs3;
      end
   end

endmodule
